// File: rtl/de2i_150_button_svc_pkg.sv
// Shared constants for the DE2i-150 button PIO servicer: PIO register
// offsets and the servicing FSM state encoding.
package de2i_150_button_svc_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_CLR0 = 3'd1,
        ST_IDLE = 3'd2,
        ST_MASK = 3'd3,
        ST_RD   = 3'd4,
        ST_CLR  = 3'd5
    } state_t;

endpackage

// File: rtl/de2i_150_button_svc_if.sv
// Avalon-MM bus between the button servicer (master) and the PIO slave port.
interface de2i_150_button_svc_if;

    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic        pio_irq;

    modport master (
        output pio_address, pio_chipselect, pio_write_n, pio_writedata,
        input  pio_readdata, pio_irq
    );

    modport slave (
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
        output pio_readdata, pio_irq
    );

endinterface

// File: rtl/de2i_150_button_svc_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module de2i_150_button_svc_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             empty_s;
    logic             full_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty_s   = (count_r == (AW+1)'(0));
    assign full_s    = (count_r == (AW+1)'(DEPTH));
    assign pop_ok_s  = pop && !empty_s;
    assign push_ok_s = push && !full_s;

    assign valid = !empty_s;
    assign data  = mem_r[rd_ptr_r];
    assign level = count_r;

    // Storage array; written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/de2i_150_button_svc.sv
// Hardware servicer for the 4-bit button PIO: programs the irq mask, services
// edge-capture interrupts and queues captured edge bitmasks in a FIFO.
module de2i_150_button_svc
    import de2i_150_button_svc_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [WIDTH-1:0] MASK_INIT  = 4'hF,
    localparam int              LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    de2i_150_button_svc_if.master         pio,
    input  logic                          mask_wr,
    input  logic [WIDTH-1:0]              mask_data,
    output logic                          evt_valid,
    output logic [WIDTH-1:0]              evt_data,
    input  logic                          evt_ready,
    output logic [LW-1:0]                 evt_level,
    output logic                          busy
);

    state_t           state_r;
    state_t           state_s;
    logic             armed_r;
    logic             pend_r;
    logic [WIDTH-1:0] pend_data_r;
    logic [WIDTH-1:0] mask_reg_r;
    logic             cs_r;
    logic             wn_r;
    logic [1:0]       addr_r;
    logic [31:0]      wd_r;
    logic             busy_r;
    logic             cs_s;
    logic             wn_s;
    logic [1:0]       addr_s;
    logic [31:0]      wd_s;
    logic             fifo_full_s;
    logic [WIDTH-1:0] capture_s;
    logic             push_s;
    logic             unused_rd_s;

    assign fifo_full_s = (evt_level == LW'(FIFO_DEPTH));
    assign capture_s   = pio.pio_readdata[WIDTH-1:0] & mask_reg_r;
    assign push_s      = (state_r == ST_CLR) && (capture_s != '0);
    assign unused_rd_s = ^pio.pio_readdata[31:WIDTH];

    // Next-state logic of the servicing FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_INIT: begin
                // Hold INIT for the first cycle after reset so its write is visible.
                if (armed_r) state_s = ST_CLR0;
                else         state_s = ST_INIT;
            end
            ST_CLR0: state_s = ST_IDLE;
            ST_IDLE: begin
                if (pend_r)                         state_s = ST_MASK;
                else if (pio.pio_irq && !fifo_full_s) state_s = ST_RD;
                else                                state_s = ST_IDLE;
            end
            ST_MASK: state_s = ST_IDLE;
            ST_RD:   state_s = ST_CLR;
            ST_CLR:  state_s = ST_IDLE;
            default: state_s = ST_INIT;
        endcase
    end

    // Bus command for the upcoming state, loaded into the output registers.
    always_comb begin
        cs_s   = 1'b0;
        wn_s   = 1'b1;
        addr_s = PIO_ADDR_DATA;
        wd_s   = 32'd0;
        case (state_s)
            ST_INIT: begin
                cs_s   = 1'b1;
                wn_s   = 1'b0;
                addr_s = PIO_ADDR_MASK;
                wd_s   = {{(32-WIDTH){1'b0}}, MASK_INIT};
            end
            ST_MASK: begin
                cs_s   = 1'b1;
                wn_s   = 1'b0;
                addr_s = PIO_ADDR_MASK;
                wd_s   = {{(32-WIDTH){1'b0}}, pend_data_r};
            end
            ST_RD: begin
                cs_s   = 1'b1;
                wn_s   = 1'b1;
                addr_s = PIO_ADDR_EDGE;
            end
            ST_CLR0, ST_CLR: begin
                cs_s   = 1'b1;
                wn_s   = 1'b0;
                addr_s = PIO_ADDR_EDGE;
            end
            default: begin
                cs_s   = 1'b0;
                wn_s   = 1'b1;
                addr_s = PIO_ADDR_DATA;
                wd_s   = 32'd0;
            end
        endcase
    end

    // State register, registered bus drivers and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_INIT;
            armed_r <= 1'b0;
            cs_r    <= 1'b0;
            wn_r    <= 1'b1;
            addr_r  <= PIO_ADDR_DATA;
            wd_r    <= 32'd0;
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            armed_r <= 1'b1;
            cs_r    <= cs_s;
            wn_r    <= wn_s;
            addr_r  <= addr_s;
            wd_r    <= wd_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Mask request latch; mask_reg follows the value being written to the PIO.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r      <= 1'b0;
            pend_data_r <= '0;
            mask_reg_r  <= MASK_INIT;
        end else begin
            if (mask_wr) begin
                pend_r      <= 1'b1;
                pend_data_r <= mask_data;
            end else if (state_s == ST_MASK) begin
                pend_r <= 1'b0;
            end
            if (state_s == ST_MASK) begin
                mask_reg_r <= pend_data_r;
            end
        end
    end

    assign pio.pio_chipselect = cs_r;
    assign pio.pio_write_n    = wn_r;
    assign pio.pio_address    = addr_r;
    assign pio.pio_writedata  = wd_r;
    assign busy               = busy_r;

    de2i_150_button_svc_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (capture_s),
        .pop       (evt_ready),
        .valid     (evt_valid),
        .data      (evt_data),
        .level     (evt_level)
    );

endmodule

// File: tb/tb_de2i_150_button_svc.sv
// Self-checking bench: behavioural PIO slave model, directed button presses,
// and a scoreboard queue of expected edge bitmasks checked on every pop.
module tb_de2i_150_button_svc;

    logic       clk = 1'b0;
    logic       reset;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic       evt_valid;
    logic [3:0] evt_data;
    logic       evt_ready;
    logic [3:0] evt_level;
    logic       busy;

    logic [3:0]  btn;
    logic [3:0]  in_q;
    logic [3:0]  edge_cap;
    logic [3:0]  irq_mask;
    logic [31:0] rdata;
    logic [3:0]  exp_v;
    logic [3:0]  exp_q[$];
    int          errors = 0;
    int          checks = 0;

    de2i_150_button_svc_if pif ();

    de2i_150_button_svc #(
        .WIDTH      (4),
        .FIFO_DEPTH (8),
        .MASK_INIT  (4'hF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pio       (pif),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ready (evt_ready),
        .evt_level (evt_level),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // PIO model: falling-edge capture, clear-on-write wins over a new edge.
    always @(posedge clk) begin
        if (reset) begin
            in_q     <= 4'd0;
            edge_cap <= 4'd0;
            irq_mask <= 4'd0;
            rdata    <= 32'd0;
        end else begin
            in_q <= btn;
            if (pif.pio_chipselect && !pif.pio_write_n && pif.pio_address == 2'd3)
                edge_cap <= 4'd0;
            else
                edge_cap <= edge_cap | (in_q & ~btn);
            if (pif.pio_chipselect && !pif.pio_write_n && pif.pio_address == 2'd2)
                irq_mask <= pif.pio_writedata[3:0];
            if (pif.pio_chipselect && pif.pio_write_n)
                rdata <= (pif.pio_address == 2'd3) ? {28'd0, edge_cap} :
                         (pif.pio_address == 2'd2) ? {28'd0, irq_mask} : {28'd0, btn};
            else
                rdata <= 32'd0;
        end
    end
    assign pif.pio_irq      = |(edge_cap & irq_mask);
    assign pif.pio_readdata = rdata;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic cs, input logic wn,
                             input logic [1:0] a, input logic [31:0] wd);
        check_val({tag, "_cs"}, {31'd0, pif.pio_chipselect}, {31'd0, cs});
        check_val({tag, "_wn"}, {31'd0, pif.pio_write_n}, {31'd0, wn});
        check_val({tag, "_addr"}, {30'd0, pif.pio_address}, {30'd0, a});
        check_val({tag, "_wd"}, pif.pio_writedata, wd);
    endtask

    // Scoreboard: every accepted pop must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check_val("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_v = exp_q.pop_front();
                check_val("sb_evt", {28'd0, evt_data}, {28'd0, exp_v});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle C, the first cycle with the capture visible.
    task automatic press(input logic [3:0] bits);
        btn = bits;
        tick();
        btn = 4'd0;
        tick();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        evt_ready = 1'b1;
        while (evt_level != 4'd0 && n < 64) begin
            tick();
            n++;
        end
        evt_ready = 1'b0;
        check_val(tag, {28'd0, evt_level}, 32'd0);
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_wr   = 1'b1;
        mask_data = m;
        tick();
        mask_wr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; btn = 4'd0; mask_wr = 1'b0; mask_data = 4'd0; evt_ready = 1'b0;
        repeat (3) tick();
        check_bus("rst", 1'b0, 1'b1, 2'd0, 32'd0);
        check_val("rst_valid", {31'd0, evt_valid}, 32'd0);
        check_val("rst_level", {28'd0, evt_level}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd1);

        reset = 1'b0;
        tick();
        check_bus("init", 1'b1, 1'b0, 2'd2, 32'h0000_000F);
        check_val("init_busy", {31'd0, busy}, 32'd1);
        tick();
        check_bus("clr0", 1'b1, 1'b0, 2'd3, 32'd0);
        check_val("clr0_busy", {31'd0, busy}, 32'd1);
        tick();
        check_val("idle_busy", {31'd0, busy}, 32'd0);
        check_bus("idle", 1'b0, 1'b1, 2'd0, 32'd0);
        check_val("idle_valid", {31'd0, evt_valid}, 32'd0);

        // Button 1: service latency.
        exp_q.push_back(4'h2);
        press(4'h2);
        check_val("b1_irq", {31'd0, pif.pio_irq}, 32'd1);
        tick();
        check_bus("b1_rd", 1'b1, 1'b1, 2'd3, 32'd0);
        tick();
        check_val("b1_clr_cs", {31'd0, pif.pio_chipselect}, 32'd1);
        check_val("b1_clr_wn", {31'd0, pif.pio_write_n}, 32'd0);
        check_val("b1_clr_addr", {30'd0, pif.pio_address}, 32'd3);
        tick();
        check_val("b1_valid", {31'd0, evt_valid}, 32'd1);
        check_val("b1_data", {28'd0, evt_data}, 32'h2);
        check_val("b1_level", {28'd0, evt_level}, 32'd1);
        check_val("b1_irq_fall", {31'd0, pif.pio_irq}, 32'd0);
        drain("b1_drain");

        // Mask reprogram to 0x1.
        set_mask(4'h1);
        tick();
        check_bus("mask_wr", 1'b1, 1'b0, 2'd2, 32'h1);
        tick();
        press(4'h4);
        check_val("mask_noirq", {31'd0, pif.pio_irq}, 32'd0);
        repeat (5) tick();
        check_val("mask_noevt", {28'd0, evt_level}, 32'd0);
        exp_q.push_back(4'h1);
        press(4'h1);
        repeat (5) tick();
        check_val("mask_level", {28'd0, evt_level}, 32'd1);
        check_val("mask_data", {28'd0, evt_data}, 32'h1);
        drain("mask_drain");
        set_mask(4'hF);
        repeat (3) tick();

        // FIFO full and merged capture.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(4'(1 << (i % 4)));
            press(4'(1 << (i % 4)));
            repeat (5) tick();
        end
        check_val("full_level", {28'd0, evt_level}, 32'd8);
        press(4'h1);
        repeat (4) tick();
        press(4'h2);
        repeat (4) tick();
        exp_q.push_back(4'h3);
        check_val("full_level2", {28'd0, evt_level}, 32'd8);
        check_val("full_busy", {31'd0, busy}, 32'd0);
        check_val("full_irq", {31'd0, pif.pio_irq}, 32'd1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        repeat (5) tick();
        check_val("full_refill", {28'd0, evt_level}, 32'd8);
        check_val("full_irq_clr", {31'd0, pif.pio_irq}, 32'd0);
        drain("full_drain");

        // Simultaneous push and pop at level 3.
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(4'(1 << i));
            press(4'(1 << i));
            repeat (5) tick();
        end
        check_val("pp_level3", {28'd0, evt_level}, 32'd3);
        exp_q.push_back(4'h8);
        press(4'h8);
        tick();
        tick();
        check_bus("pp_clr", 1'b1, 1'b0, 2'd3, 32'd0);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check_val("pp_level", {28'd0, evt_level}, 32'd3);
        drain("pp_drain");

        // Reset asserted during CLR.
        exp_q.push_back(4'h2);
        press(4'h2);
        repeat (5) tick();
        press(4'h1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        check_bus("mrst", 1'b0, 1'b1, 2'd0, 32'd0);
        check_val("mrst_valid", {31'd0, evt_valid}, 32'd0);
        check_val("mrst_level", {28'd0, evt_level}, 32'd0);
        check_val("mrst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        check_bus("mrst_init", 1'b1, 1'b0, 2'd2, 32'h0000_000F);
        tick();
        check_bus("mrst_clr0", 1'b1, 1'b0, 2'd3, 32'd0);
        tick();
        check_val("mrst_idle", {31'd0, busy}, 32'd0);
        exp_q.push_back(4'h4);
        press(4'h4);
        repeat (5) tick();
        check_val("post_level", {28'd0, evt_level}, 32'd1);
        drain("post_drain");
        check_val("sb_left", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
